wb_collect: RTL and testbench

Write-back result collector for the nux backend. Consumes the result buses of up to eight functional units, buffers each in a small per-source FIFO with valid/ready backpressure, and drains them onto the single GPR write port using a round-robin arbiter. It is the consuming (write-back) side of the functional-unit result path: FUs drive results, this block serialises them into the register file.

---
 rtl/wb_collect_if.sv | 23 ++
 rtl/wb_collect.sv | 89 ++++++++
 tb/tb_wb_collect.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_collect_if.sv
// wb_collect_if: result-bus and GPR write-port bundle between functional units and the write-back collector
interface wb_collect_if #(
  parameter int N_SRC  = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [N_SRC-1:0]        res_valid;
  logic [N_SRC-1:0]        res_ready;
  logic [N_SRC*ADDR_W-1:0] res_dest;
  logic [N_SRC*DATA_W-1:0] res_data;
  logic                    gpr_we;
  logic [ADDR_W-1:0]       gpr_waddr;
  logic [DATA_W-1:0]       gpr_wdata;
  logic [2:0]              gpr_src;
  modport master (
    output res_valid, res_dest, res_data,
    input  res_ready, gpr_we, gpr_waddr, gpr_wdata, gpr_src
  );
  modport slave (
    input  res_valid, res_dest, res_data,
    output res_ready, gpr_we, gpr_waddr, gpr_wdata, gpr_src
  );
endinterface

// File: rtl/wb_collect.sv
// wb_collect: per-source result FIFOs drained round-robin onto the single GPR write port
module wb_collect #(
  parameter int N_SRC  = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  wb_collect_if.slave  bus,
  output logic         busy
);
  localparam int EW = ADDR_W + DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [N_SRC-1:0]    nonempty;
  logic [N_SRC-1:0]    push;
  logic [N_SRC-1:0]    pop;
  logic [N_SRC*EW-1:0] heads;
  logic [N_SRC-1:0]    rot;
  logic [3:0]          sum;
  logic [2:0]          rr_ptr;
  logic [2:0]          gnt;
  logic                gnt_vld;
  logic [EW-1:0]       win;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    assign nonempty[i]          = count != '0;
    assign bus.res_ready[i]     = count != CW'(DEPTH);
    assign push[i]              = bus.res_valid[i] & bus.res_ready[i];
    assign pop[i]               = gnt_vld && gnt == 3'(i);
    assign heads[i*EW +: EW]    = mem[rd_ptr];
    // occupancy and pointers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count  <= count + CW'(push[i]) - CW'(pop[i]);
        rd_ptr <= rd_ptr + PW'(pop[i]);
        wr_ptr <= wr_ptr + PW'(push[i]);
      end
    // entry storage needs no reset; only slots covered by count are ever read out
    always_ff @(posedge clk)
      if (push[i] && !flush) mem[wr_ptr] <= {bus.res_dest[i*ADDR_W +: ADDR_W], bus.res_data[i*DATA_W +: DATA_W]};
  end
  // rotate the request vector so the search starts at rr_ptr, then map the winner back
  always_comb begin
    rot     = N_SRC'({nonempty, nonempty} >> rr_ptr);
    gnt_vld = |rot;
    sum     = '0;
    for (int k = N_SRC - 1; k >= 0; k--) if (rot[k]) sum = 4'(k) + {1'b0, rr_ptr};
    gnt     = sum >= 4'(N_SRC) ? 3'(sum - 4'(N_SRC)) : sum[2:0];
  end
  // select the granted FIFO head
  always_comb begin
    win = '0;
    for (int k = 0; k < N_SRC; k++) if (gnt == 3'(k)) win = heads[k*EW +: EW];
  end
  // registered write port and round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.gpr_we    <= 1'b0;
      bus.gpr_waddr <= '0;
      bus.gpr_wdata <= '0;
      bus.gpr_src   <= '0;
      rr_ptr        <= '0;
    end else if (flush) begin
      bus.gpr_we <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      bus.gpr_we <= gnt_vld;
      if (gnt_vld) begin
        {bus.gpr_waddr, bus.gpr_wdata} <= win;
        bus.gpr_src <= gnt;
        rr_ptr      <= gnt == 3'(N_SRC - 1) ? 3'd0 : gnt + 3'd1;
      end
    end
  assign busy = (|nonempty) | bus.gpr_we;
endmodule

// File: tb/tb_wb_collect.sv
// tb_wb_collect: randomized and directed checks of wb_collect against a queue-based reference model
module tb_wb_collect;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush5 = 1'b0;
  logic busy;
  logic busy5;
  wb_collect_if #(.N_SRC(8), .ADDR_W(5), .DATA_W(32)) bus ();
  wb_collect_if #(.N_SRC(5), .ADDR_W(5), .DATA_W(32)) bus5 ();
  wb_collect #(.N_SRC(8), .ADDR_W(5), .DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .busy(busy));
  wb_collect #(.N_SRC(5), .ADDR_W(5), .DATA_W(32), .DEPTH(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush5), .bus(bus5), .busy(busy5));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] q [8][$];
  int          ptr;
  logic        m_we, m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_src;
  logic [7:0]  m_ready, obs_ready;
  function automatic void model_reset();
    for (int i = 0; i < 8; i++) q[i].delete();
    ptr = 0;
    m_we = 1'b0;
    m_busy = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_src = '0;
    m_ready = 8'hFF;
  endfunction
  // drive one cycle of inputs, advance the model across the edge, return 1ns after it
  task automatic step(input logic [7:0] v, input logic [39:0] d, input logic [255:0] x, input logic fl);
    int g;
    logic [36:0] e;
    bus.res_valid = v;
    bus.res_dest = d;
    bus.res_data = x;
    flush = fl;
    #1;
    obs_ready = bus.res_ready;
    for (int i = 0; i < 8; i++) m_ready[i] = q[i].size() != 2;
    g = -1;
    for (int k = 0; k < 8; k++) if (g < 0 && q[(ptr + k) % 8].size() != 0) g = (ptr + k) % 8;
    if (fl) begin
      for (int i = 0; i < 8; i++) q[i].delete();
      ptr = 0;
      m_we = 1'b0;
    end else begin
      m_we = g >= 0;
      if (g >= 0) begin
        e = q[g].pop_front();
        {m_addr, m_data} = e;
        m_src = 3'(g);
        ptr = (g + 1) % 8;
      end
      for (int i = 0; i < 8; i++) if (v[i] && m_ready[i]) q[i].push_back({d[i*5 +: 5], x[i*32 +: 32]});
    end
    @(posedge clk);
    #1;
    m_busy = m_we;
    for (int i = 0; i < 8; i++) if (q[i].size() != 0) m_busy = 1'b1;
    bus.res_valid = '0;
    flush = 1'b0;
  endtask
  task automatic test_reset();
    n_cmp++; if (bus.gpr_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.gpr_we); end
    n_cmp++; if ({bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src} !== 40'h0) begin n_bad++; $display("FAIL reset_port: got %h %h %h want 0", bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src); end
    n_cmp++; if (bus.res_ready !== 8'hFF) begin n_bad++; $display("FAIL reset_ready: got %h want ff", bus.res_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (bus5.res_ready !== 5'h1F) begin n_bad++; $display("FAIL reset_ready5: got %h want 1f", bus5.res_ready); end
  endtask
  task automatic test_wrap5();
    bus5.res_valid = 5'b01000;
    bus5.res_dest[15 +: 5] = 5'd3;
    bus5.res_data[96 +: 32] = 32'h3333;
    @(posedge clk); #1;
    bus5.res_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if ({bus5.gpr_we, bus5.gpr_src} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL wrap5_first: got we=%b src=%0d want we=1 src=3", bus5.gpr_we, bus5.gpr_src); end
    bus5.res_valid = 5'b10001;
    bus5.res_dest[0 +: 5] = 5'd10;
    bus5.res_data[0 +: 32] = 32'hA0;
    bus5.res_dest[20 +: 5] = 5'd14;
    bus5.res_data[128 +: 32] = 32'hA4;
    @(posedge clk); #1;
    bus5.res_valid = '0;
    n_cmp++; if (bus5.gpr_we !== 1'b0) begin n_bad++; $display("FAIL wrap5_gap: got we=%b want 0", bus5.gpr_we); end
    @(posedge clk); #1;
    n_cmp++; if ({bus5.gpr_we, bus5.gpr_src, bus5.gpr_waddr, bus5.gpr_wdata} !== {1'b1, 3'd4, 5'd14, 32'hA4}) begin n_bad++; $display("FAIL wrap5_g4: got we=%b src=%0d a=%0d d=%h want 1 4 14 a4", bus5.gpr_we, bus5.gpr_src, bus5.gpr_waddr, bus5.gpr_wdata); end
    @(posedge clk); #1;
    n_cmp++; if ({bus5.gpr_we, bus5.gpr_src, bus5.gpr_waddr, bus5.gpr_wdata} !== {1'b1, 3'd0, 5'd10, 32'hA0}) begin n_bad++; $display("FAIL wrap5_g0: got we=%b src=%0d a=%0d d=%h want 1 0 10 a0", bus5.gpr_we, bus5.gpr_src, bus5.gpr_waddr, bus5.gpr_wdata); end
    bus5.res_valid = 5'b00011;
    @(posedge clk); #1;
    bus5.res_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if ({bus5.gpr_we, bus5.gpr_src} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL wrap5_ptr1: got we=%b src=%0d want we=1 src=1", bus5.gpr_we, bus5.gpr_src); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy5 !== 1'b0) begin n_bad++; $display("FAIL wrap5_idle: got busy=%b want 0", busy5); end
  endtask
  task automatic test_single();
    logic [39:0] d = '0;
    logic [255:0] x = '0;
    d[15 +: 5] = 5'd7;
    x[96 +: 32] = 32'hDEADBEEF;
    step(8'h08, d, x, 1'b0);
    n_cmp++; if (bus.gpr_we !== 1'b0) begin n_bad++; $display("FAIL single_early: got we=%b want 0", bus.gpr_we); end
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src} !== {1'b1, 5'd7, 32'hDEADBEEF, 3'd3}) begin n_bad++; $display("FAIL single_write: got we=%b a=%0d d=%h s=%0d want 1 7 deadbeef 3", bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src); end
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if ({bus.gpr_we, busy} !== 2'b00) begin n_bad++; $display("FAIL single_done: got we=%b busy=%b want 0 0", bus.gpr_we, busy); end
  endtask
  task automatic test_all8();
    logic [39:0] d = '0;
    logic [255:0] x = '0;
    step(8'h00, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d[i*5 +: 5] = 5'(i);
      x[i*32 +: 32] = 32'h100 + i;
    end
    step(8'hFF, d, x, 1'b0);
    n_cmp++; if (bus.gpr_we !== 1'b0) begin n_bad++; $display("FAIL all8_early: got we=%b want 0", bus.gpr_we); end
    for (int k = 0; k < 8; k++) begin
      step(8'h00, '0, '0, 1'b0);
      n_cmp++; if ({bus.gpr_we, bus.gpr_src, bus.gpr_waddr, bus.gpr_wdata} !== {1'b1, 3'(k), 5'(k), 32'h100 + k}) begin n_bad++; $display("FAIL all8_w%0d: got we=%b s=%0d a=%0d d=%h", k, bus.gpr_we, bus.gpr_src, bus.gpr_waddr, bus.gpr_wdata); end
    end
    step(8'h81, '0, '0, 1'b0);
    n_cmp++; if (bus.gpr_we !== 1'b0) begin n_bad++; $display("FAIL all8_end: got we=%b want 0", bus.gpr_we); end
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if ({bus.gpr_we, bus.gpr_src} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL all8_wrap: got we=%b s=%0d want 1 0", bus.gpr_we, bus.gpr_src); end
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if ({bus.gpr_we, bus.gpr_src} !== {1'b1, 3'd7}) begin n_bad++; $display("FAIL all8_after: got we=%b s=%0d want 1 7", bus.gpr_we, bus.gpr_src); end
  endtask
  task automatic test_backpressure();
    logic [39:0] d;
    logic [255:0] x;
    logic saw_full5 = 1'b0;
    for (int c = 0; c < 44; c++) begin
      d = {$urandom, $urandom};
      x = '0;
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = {16'hB0B0, 8'(c), 8'(i)};
      step(c < 30 ? 8'h3F : 8'h00, d, x, 1'b0);
      if (obs_ready[5] === 1'b0) saw_full5 = 1'b1;
      n_cmp++; if (obs_ready !== m_ready) begin n_bad++; $display("FAIL bp_ready c=%0d: got %h want %h", c, obs_ready, m_ready); end
      n_cmp++; if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src, busy} !== {m_we, m_addr, m_data, m_src, m_busy}) begin n_bad++; $display("FAIL bp_port c=%0d: got %b %0d %h %0d %b want %b %0d %h %0d %b", c, bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src, busy, m_we, m_addr, m_data, m_src, m_busy); end
    end
    n_cmp++; if (saw_full5 !== 1'b1) begin n_bad++; $display("FAIL bp_full5: got %b want 1", saw_full5); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got busy=%b want 0", busy); end
  endtask
  task automatic test_flush();
    step(8'h07, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
    step(8'h07, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
    step(8'h18, {$urandom, $urandom}, {8{$urandom}}, 1'b1);
    n_cmp++; if ({bus.res_ready, bus.gpr_we, busy} !== {8'hFF, 1'b0, 1'b0}) begin n_bad++; $display("FAIL flush_state: got ready=%h we=%b busy=%b want ff 0 0", bus.res_ready, bus.gpr_we, busy); end
    for (int c = 0; c < 3; c++) begin
      step(8'h00, '0, '0, 1'b0);
      n_cmp++; if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src} !== {1'b0, m_addr, m_data, m_src}) begin n_bad++; $display("FAIL flush_quiet c=%0d: got we=%b a=%0d d=%h s=%0d", c, bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src); end
    end
  endtask
  task automatic test_random();
    logic [255:0] x;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
      step(8'($urandom), {$urandom, $urandom}, x, $urandom_range(0, 24) == 0);
      n_cmp++; if (obs_ready !== m_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %h want %h", c, obs_ready, m_ready); end
      n_cmp++; if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src, busy} !== {m_we, m_addr, m_data, m_src, m_busy}) begin n_bad++; $display("FAIL rnd_port c=%0d: got %b %0d %h %0d %b want %b %0d %h %0d %b", c, bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src, busy, m_we, m_addr, m_data, m_src, m_busy); end
    end
  endtask
  task automatic test_async_reset();
    logic [39:0] d = '0;
    logic [255:0] x = '0;
    step(8'h46, {$urandom, $urandom}, {8{$urandom}}, 1'b0);
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if (bus.gpr_we !== m_we) begin n_bad++; $display("FAIL arst_pre: got we=%b want %b", bus.gpr_we, m_we); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.gpr_we, busy, bus.res_ready} !== {1'b0, 1'b0, 8'hFF}) begin n_bad++; $display("FAIL arst_now: got we=%b busy=%b ready=%h want 0 0 ff", bus.gpr_we, busy, bus.res_ready); end
    #2 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    d[30 +: 5] = 5'd12;
    x[192 +: 32] = 32'hC0FFEE01;
    step(8'h40, d, x, 1'b0);
    n_cmp++; if (bus.gpr_we !== 1'b0) begin n_bad++; $display("FAIL arst_early: got we=%b want 0", bus.gpr_we); end
    step(8'h00, '0, '0, 1'b0);
    n_cmp++; if ({bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src} !== {1'b1, 5'd12, 32'hC0FFEE01, 3'd6}) begin n_bad++; $display("FAIL arst_write: got we=%b a=%0d d=%h s=%0d want 1 12 c0ffee01 6", bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.gpr_src); end
  endtask
  initial begin
    bus.res_valid = '0;
    bus.res_dest = '0;
    bus.res_data = '0;
    bus5.res_valid = '0;
    bus5.res_dest = '0;
    bus5.res_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_wrap5();
    test_single();
    test_all8();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
